// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and parameter bounds for the data-memory arbiter.
package dmem_arb_pkg;
    typedef enum logic {PRI_CPU = 1'b0, PRI_EXT = 1'b1} arb_state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;
    localparam int RD_LAT_MAX = 4;
    localparam int MAX_WAIT_MAX = 15;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of {valid, owner} tags for in-flight reads.
module rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_valid,
    input  owner_t in_owner,
    output logic   out_valid,
    output owner_t out_owner
);
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] own;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld <= RD_LAT'({vld, in_valid});
            own <= RD_LAT'({own, in_owner == OWN_EXT});
        end
    end
    assign out_valid = vld[RD_LAT-1];
    assign out_owner = own[RD_LAT-1] ? OWN_EXT : OWN_CPU;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU and an ext loader,
// CPU-first with a starvation counter, routing each read return to its issuer.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    arb_state_t state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic ext_win, cpu_gnt, tag_valid;
    owner_t tag_owner;
    logic [DW-1:0] cpu_hold, ext_hold;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= PRI_CPU;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end
    // Look at the updated count so ext wins on the very next cycle it requests.
    always_comb begin
        wait_nxt  = (ext_req & ~ext_gnt) ? (wait_cnt == '1 ? wait_cnt : wait_cnt + 1'b1) : '0;
        state_nxt = state == PRI_CPU ? (int'(wait_nxt) >= MAX_WAIT ? PRI_EXT : PRI_CPU)
                                     : (ext_gnt | ~ext_req ? PRI_CPU : PRI_EXT);
    end
    always_comb begin
        ext_win   = state == PRI_EXT ? ext_req : ext_req & ~cpu_req;
        ext_gnt   = reset & ext_win;
        cpu_gnt   = reset & cpu_req & ~ext_win;
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_addr  = ext_gnt ? ext_addr : cpu_gnt ? cpu_addr : '0;
        mem_wdata = ext_gnt ? ext_wdata : cpu_gnt ? cpu_wdata : '0;
        mem_we    = ext_gnt ? ext_we : cpu_gnt & cpu_we;
        mem_re    = (ext_gnt & ~ext_we) | (cpu_gnt & ~cpu_we);
    end
    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (mem_re),
        .in_owner  (ext_gnt ? OWN_EXT : OWN_CPU),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );
    assign cpu_rvalid = tag_valid & (tag_owner == OWN_CPU);
    assign ext_rvalid = tag_valid & (tag_owner == OWN_EXT);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold;
    assign ext_rdata  = ext_rvalid ? mem_rdata : ext_hold;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_hold <= '0;
            ext_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= mem_rdata;
            if (ext_rvalid) ext_hold <= mem_rdata;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 16-bit data memory port between two requesters: the CPU execute stage (port "cpu") and an external loader/DMA port (port "ext").
- One access is issued per cycle. The CPU has priority, and a starvation counter guarantees the ext port forward progress.
- The block stalls the CPU when its request loses arbitration. It tracks outstanding reads and routes each read return to the requester that issued it.
- It sits between the cpu execute/memory stage and datamem.

Parameters:
- AW, 16, address width
- DW, 16, data width
- RD_LAT, 1, datamem read latency in cycles (valid range 1..4)
- MAX_WAIT, 4, maximum number of consecutive cycles ext may be denied while requesting (valid range 1..15)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_stall  out  1  CPU request not accepted this cycle; the CPU pipeline holds
- cpu_rdata  out  DW  read return data for the CPU
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
- ext_req  in  1  ext access request
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  AW  ext address
- ext_wdata  in  DW  ext write data
- ext_gnt  out  1  ext request accepted this cycle
- ext_rdata  out  DW  read return data for ext
- ext_rvalid  out  1  ext_rdata valid (one-cycle pulse)
- mem_addr  out  AW  to datamem
- mem_we  out  1  to datamem write_enable
- mem_re  out  1  to datamem read_enable
- mem_wdata  out  DW  to datamem
- mem_rdata  in  DW  from datamem; valid RD_LAT cycles after mem_re

Behaviour:
- Arbitration states:
  - PRI_CPU (reset state): cpu_req wins; ext is granted only when cpu_req=0.
  - PRI_EXT: ext_req wins; the CPU is stalled if both request.
- wait_cnt (4 bits):
  - Increments in any cycle where ext_req=1 and ext_gnt=0.
  - Clears on ext_gnt or when ext_req=0.
  - Saturates at 15.
- State transitions:
  - PRI_CPU -> PRI_EXT when wait_cnt reaches MAX_WAIT. The next ext_req cycle is then granted.
  - PRI_EXT -> PRI_CPU on the cycle after an ext grant.
  - PRI_EXT -> PRI_CPU if ext_req drops before being granted.
- Grant signals are combinational from the current state and the requests:
  - ext_gnt = granted ext.
  - cpu_stall = cpu_req & !cpu_granted.
- Requester obligation: a requester holds req/we/addr/wdata stable until it is granted (cpu_stall=0 or ext_gnt=1). The arbiter does not latch requests.
- Memory drive:
  - mem_addr, mem_wdata and mem_we are combinational from the granted requester.
  - mem_re = granted & !we.
  - When no grant: mem_we=0, mem_re=0, and mem_addr/mem_wdata=0.
- Read return tracking:
  - A RD_LAT-deep shift pipeline carries {valid, owner} for each issued read.
  - At pipeline depth RD_LAT, valid routes mem_rdata to the owner's rdata and asserts that owner's rvalid for exactly one cycle.
  - The non-owner's rvalid=0, and its rdata holds its last value.
  - rdata is combinational pass-through of mem_rdata when rvalid is high.
- Writes complete in the grant cycle; there is no write acknowledge beyond grant.
- Back-to-back accesses: reads may issue every cycle; RD_LAT reads may be in flight at once.
- Simultaneous new grant and read return in one cycle: both are handled independently.
- Reset assertion, including mid-operation:
  - State -> PRI_CPU, wait_cnt=0, and all in-flight read tags are cleared. Pending returns are discarded and no rvalid fires.
  - cpu_rvalid=0, ext_rvalid=0, and cpu_rdata/ext_rdata=0.
  - The combinational outputs follow the reset state: cpu_stall=0 if cpu_req=0, and cpu_stall=1 if cpu_req=1 with ext favoured.
- During reset, grants are suppressed: mem_we=0, mem_re=0, ext_gnt=0, and cpu_stall=cpu_req.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef arb_state_t {PRI_CPU, PRI_EXT};
  - typedef owner_t {OWN_CPU, OWN_EXT};
  - constants for the RD_LAT and MAX_WAIT upper bounds.
- One sub-module, rd_tag_pipe: a parameterised RD_LAT-deep shift register of {valid, owner} with asynchronous active-low clear.

Test Plan:
1. Reset asserted (reset=0) with cpu_req=1 -> cpu_stall=1, mem_re=0, mem_we=0, both rvalid=0. Release reset, CPU read of addr 0x0010 (mem holds 0xBEEF) -> cpu_stall=0, and cpu_rvalid=1 with cpu_rdata=0xBEEF exactly RD_LAT=1 cycle later; ext_rvalid stays 0.
2. cpu_req and ext_req both held high continuously, MAX_WAIT=4 -> CPU granted 4 cycles, ext_gnt=1 in cycle 5 with cpu_stall=1 that cycle, then the CPU is granted again; the pattern repeats every 5 cycles.
3. ext write addr 0x0020 data 0x1234 while cpu_req=0 -> ext_gnt=1 the same cycle with mem_we=1, mem_addr=0x0020, mem_wdata=0x1234. A subsequent CPU read of 0x0020 returns 0x1234.
4. Interleaved reads with RD_LAT=2: cycle0 CPU reads 0x0001 (=0xAAAA), cycle1 ext reads 0x0002 (=0x5555) -> cpu_rvalid at cycle2 with 0xAAAA, ext_rvalid at cycle3 with 0x5555; never both rvalid in the same cycle.
5. Reset asserted one cycle after issuing an ext read, RD_LAT=2 -> no ext_rvalid ever fires for that read; after release, state is PRI_CPU and wait_cnt=0 (the next simultaneous request grants the CPU).
6. ext_req pulsed for 3 cycles under CPU contention, then dropped -> wait_cnt clears, state stays PRI_CPU, no ext_gnt issued.
